// File: rtl/sbus_pkg.sv
// Shared types and constants for the strobe-bus initiator and its responders.
package sbus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } sbus_state_t;

    localparam logic [15:0] ADDR_A = 16'h0100;
    localparam logic [15:0] ADDR_W = 16'h0110;
    localparam logic [15:0] ADDR_S = 16'h0120;

    localparam logic [31:0] S_DONE = 32'd2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sbus_initiator_if.sv
// Command/response handshake plus strobe-bus signals of the initiator.
interface sbus_initiator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_poll;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;

    logic [15:0] saddress;
    logic [31:0] sdata_in;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;

    modport master (
        input  cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata,
        input  rsp_ready, sdata_out,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        output saddress, sdata_in, srd, swr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata,
        output rsp_ready, sdata_out,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        input  saddress, sdata_in, srd, swr
    );

endinterface

// File: rtl/sbus_phase_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module sbus_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sbus_initiator.sv
// Strobe-bus initiator: one command at a time, programmable setup/strobe/hold.
// Optional read-polling is enabled by defining SBUS_POLL_EN.
module sbus_initiator
    import sbus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int POLL_MAX   = 1024
) (
    input  logic             clk,
    input  logic             n_reset,
    sbus_initiator_if.master bus
);

    localparam int TW = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;

    sbus_state_t r_state;
    sbus_state_t w_next_state;

    logic          r_cmd_ready;
    logic          r_rsp_valid;
    logic          r_srd;
    logic          r_swr;
    logic          r_write;
    logic [15:0]   r_saddress;
    logic [31:0]   r_sdata_in;
    logic [31:0]   r_rsp_rdata;

    logic          w_cmd_ready_next;
    logic          w_rsp_valid_next;
    logic          w_srd_next;
    logic          w_swr_next;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_done;
    logic          w_accept;
    logic          w_rsp_hs;
    logic          w_hold_done;
    logic          w_repoll;

    assign w_accept    = bus.cmd_valid && r_cmd_ready;
    assign w_rsp_hs    = r_rsp_valid && bus.rsp_ready;
    assign w_hold_done = (r_state == HOLD) && w_tmr_done;

    sbus_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .n_reset    (n_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_next_state = SETUP;
            SETUP:   if (w_tmr_done) w_next_state = STROBE;
            STROBE:  if (w_tmr_done) w_next_state = HOLD;
            HOLD:    if (w_tmr_done) w_next_state = w_repoll ? SETUP : RESP;
            RESP:    if (w_rsp_hs)   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Every output is registered from the next state, so it lines up with the phase it belongs to.
    always_comb begin
        w_cmd_ready_next = (w_next_state == IDLE);
        w_rsp_valid_next = (w_next_state == RESP);
        w_srd_next       = (w_next_state == STROBE) && !r_write;
        w_swr_next       = (w_next_state == STROBE) && r_write;
        w_tmr_load       = (w_next_state != r_state);
        case (w_next_state)
            SETUP:   w_tmr_val = TW'(SETUP_CYC - 1);
            STROBE:  w_tmr_val = TW'(STROBE_CYC - 1);
            HOLD:    w_tmr_val = TW'(HOLD_CYC - 1);
            default: w_tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_srd       <= 1'b0;
            r_swr       <= 1'b0;
            r_write     <= 1'b0;
            r_saddress  <= '0;
            r_sdata_in  <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_cmd_ready <= w_cmd_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_srd       <= w_srd_next;
            r_swr       <= w_swr_next;
            if (w_accept) begin
                r_write    <= bus.cmd_write;
                r_saddress <= bus.cmd_addr;
                r_sdata_in <= bus.cmd_write ? bus.cmd_wdata : 32'd0;
            end
            if (w_hold_done) begin
                r_rsp_rdata <= r_write ? 32'd0 : bus.sdata_out;
            end
        end
    end

`ifdef SBUS_POLL_EN
    localparam int PW = $clog2(POLL_MAX + 1);

    logic          r_poll;
    logic [31:0]   r_expect;
    logic [PW-1:0] r_poll_cnt;
    logic          r_rsp_timeout;
    logic          w_match;
    logic          w_last;

    assign w_match  = (bus.sdata_out == r_expect);
    assign w_last   = (r_poll_cnt == PW'(POLL_MAX - 1));
    assign w_repoll = r_poll && !w_match && !w_last;

    // r_poll_cnt counts reads already completed for the current poll command.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_poll        <= 1'b0;
            r_expect      <= '0;
            r_poll_cnt    <= '0;
            r_rsp_timeout <= 1'b0;
        end else if (w_accept) begin
            r_poll        <= bus.cmd_poll && !bus.cmd_write;
            r_expect      <= bus.cmd_wdata;
            r_poll_cnt    <= '0;
            r_rsp_timeout <= 1'b0;
        end else if (w_hold_done) begin
            r_poll_cnt    <= r_poll_cnt + 1'b1;
            r_rsp_timeout <= r_poll && !w_match && w_last;
        end
    end

    assign bus.rsp_timeout = r_rsp_timeout;
`else
    wire [31:0] w_unused_poll = {31'(POLL_MAX), bus.cmd_poll};

    assign w_repoll        = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.saddress  = r_saddress;
    assign bus.sdata_in  = r_sdata_in;
    assign bus.srd       = r_srd;
    assign bus.swr       = r_swr;

endmodule

// File: tb/tb_sbus_initiator.sv
// Directed bench for sbus_initiator: default-timing instance plus a 3/1/2 instance (POLL_MAX=4).
module tb_sbus_initiator;
    import sbus_pkg::*;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sbus_initiator_if if0 ();
    sbus_initiator_if if1 ();

    sbus_initiator u_dut0 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (if0)
    );

    sbus_initiator #(
        .SETUP_CYC  (3),
        .STROBE_CYC (1),
        .HOLD_CYC   (2),
        .POLL_MAX   (4)
    ) u_dut1 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (if1)
    );

    // Responder models and strobe monitor
    logic [31:0] rd_val0;
    logic [31:0] rd_val1;
    logic        use_seq0;
    int          seq_base0;
    int          srd_pulses0 = 0;
    int          srd_pulses1 = 0;
    int          both_high = 0;
    logic        srd_prev0 = 1'b0;
    logic        srd_prev1 = 1'b0;

    assign if0.sdata_out = use_seq0 ? (((srd_pulses0 - seq_base0) >= 3) ? 32'd2 : 32'd1) : rd_val0;
    assign if1.sdata_out = rd_val1;

    always @(negedge clk) begin
        if (if0.srd && !srd_prev0) srd_pulses0++;
        if (if1.srd && !srd_prev1) srd_pulses1++;
        srd_prev0 = if0.srd;
        srd_prev1 = if1.srd;
        if ((if0.srd && if0.swr) || (if1.srd && if1.swr)) both_high++;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int base;
        if0.cmd_valid = 1'b0; if0.cmd_write = 1'b0; if0.cmd_poll = 1'b0;
        if0.cmd_addr = '0; if0.cmd_wdata = '0; if0.rsp_ready = 1'b0;
        if1.cmd_valid = 1'b0; if1.cmd_write = 1'b0; if1.cmd_poll = 1'b0;
        if1.cmd_addr = '0; if1.cmd_wdata = '0; if1.rsp_ready = 1'b0;
        rd_val0 = '0; rd_val1 = '0; use_seq0 = 1'b0; seq_base0 = 0;

        // Reset state
        step(2);
        chk1 ("rst_cmd_ready", if0.cmd_ready, 1'b0);
        chk1 ("rst_rsp_valid", if0.rsp_valid, 1'b0);
        chk1 ("rst_srd", if0.srd, 1'b0);
        chk1 ("rst_swr", if0.swr, 1'b0);
        chk16("rst_saddress", if0.saddress, 16'h0000);
        chk32("rst_sdata_in", if0.sdata_in, 32'h0);
        chk32("rst_rsp_rdata", if0.rsp_rdata, 32'h0);
        chk1 ("rst_rsp_timeout", if0.rsp_timeout, 1'b0);
        n_reset = 1'b1;
        step(1);
        chk1 ("rel_cmd_ready", if0.cmd_ready, 1'b1);
        $display("txn reset: released, cmd_ready=%b", if0.cmd_ready);

        // Write 0x0100 <- 5
        if0.cmd_write = 1'b1; if0.cmd_addr = ADDR_A; if0.cmd_wdata = 32'd5; if0.cmd_valid = 1'b1;
        step(1);
        if0.cmd_valid = 1'b0;
        chk16("w_saddress", if0.saddress, ADDR_A);
        chk32("w_sdata_in", if0.sdata_in, 32'd5);
        chk1 ("w_ready_low", if0.cmd_ready, 1'b0);
        chk1 ("w_swr_c1", if0.swr, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            step(1);
            chk1("w_swr", if0.swr, (k == 2) || (k == 3));
            chk1("w_srd", if0.srd, 1'b0);
            chk1("w_rsp_valid", if0.rsp_valid, k == 5);
        end
        chk32("w_rsp_rdata", if0.rsp_rdata, 32'h0);
        if0.rsp_ready = 1'b1;
        step(1);
        if0.rsp_ready = 1'b0;
        chk1 ("w_rsp_done", if0.rsp_valid, 1'b0);
        chk1 ("w_ready_back", if0.cmd_ready, 1'b1);
        $display("txn write addr=0x0100 data=5 rdata=0x%08h", if0.rsp_rdata);

        // Read 0x0110 -> 0xB, response stalled 4 cycles, second command held waiting
        rd_val0 = 32'h0000_000B;
        if0.cmd_write = 1'b0; if0.cmd_addr = ADDR_W; if0.cmd_wdata = 32'hDEAD_BEEF; if0.cmd_valid = 1'b1;
        step(1);
        chk16("r_saddress", if0.saddress, ADDR_W);
        chk32("r_sdata_in", if0.sdata_in, 32'h0);
        chk1 ("r_ready_low", if0.cmd_ready, 1'b0);
        if0.cmd_write = 1'b1; if0.cmd_addr = ADDR_S; if0.cmd_wdata = 32'd7;
        for (int k = 2; k <= 5; k++) begin
            step(1);
            chk1("r_srd", if0.srd, (k == 2) || (k == 3));
            chk1("r_swr", if0.swr, 1'b0);
            chk1("r_ready_busy", if0.cmd_ready, 1'b0);
            chk1("r_rsp_valid", if0.rsp_valid, k == 5);
        end
        chk32("r_rsp_rdata", if0.rsp_rdata, 32'h0000_000B);
        rd_val0 = 32'hFFFF_0000;
        for (int k = 6; k <= 8; k++) begin
            step(1);
            chk1 ("stall_valid", if0.rsp_valid, 1'b1);
            chk32("stall_rdata", if0.rsp_rdata, 32'h0000_000B);
            chk1 ("stall_ready", if0.cmd_ready, 1'b0);
        end
        $display("txn read addr=0x0110 rdata=0x%08h", if0.rsp_rdata);
        if0.rsp_ready = 1'b1;
        step(1);
        if0.rsp_ready = 1'b0;
        chk1 ("hs_valid_drop", if0.rsp_valid, 1'b0);
        chk1 ("hs_ready_back", if0.cmd_ready, 1'b1);
        chk16("hs_saddr_kept", if0.saddress, ADDR_W);
        step(1);
        if0.cmd_valid = 1'b0;
        chk1 ("q_accepted", if0.cmd_ready, 1'b0);
        chk16("q_saddress", if0.saddress, ADDR_S);
        chk32("q_sdata_in", if0.sdata_in, 32'd7);
        step(4);
        chk1 ("q_rsp_valid", if0.rsp_valid, 1'b1);
        chk32("q_rsp_rdata", if0.rsp_rdata, 32'h0);
        if0.rsp_ready = 1'b1;
        step(1);
        if0.rsp_ready = 1'b0;
        $display("txn write addr=0x0120 data=7 (queued) rdata=0x%08h", if0.rsp_rdata);

        // Reset asserted during the write strobe
        if0.cmd_write = 1'b1; if0.cmd_addr = ADDR_A; if0.cmd_wdata = 32'd9; if0.cmd_valid = 1'b1;
        step(1);
        if0.cmd_valid = 1'b0;
        step(1);
        chk1 ("ab_swr_high", if0.swr, 1'b1);
        #2 n_reset = 1'b0;
        #1;
        chk1 ("ab_swr_async", if0.swr, 1'b0);
        chk16("ab_saddress", if0.saddress, 16'h0000);
        chk32("ab_sdata_in", if0.sdata_in, 32'h0);
        chk1 ("ab_cmd_ready", if0.cmd_ready, 1'b0);
        chk1 ("ab_rsp_valid", if0.rsp_valid, 1'b0);
        step(2);
        n_reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk1("ab_no_rsp", if0.rsp_valid, 1'b0);
            chk1("ab_no_swr", if0.swr, 1'b0);
        end
        chk1 ("ab_ready_after", if0.cmd_ready, 1'b1);
        $display("txn abort: write dropped by reset, rsp_valid=%b", if0.rsp_valid);
        rd_val0 = 32'h0000_0020;
        if0.cmd_write = 1'b0; if0.cmd_addr = ADDR_W; if0.cmd_valid = 1'b1;
        step(1);
        if0.cmd_valid = 1'b0;
        step(4);
        chk1 ("post_rsp_valid", if0.rsp_valid, 1'b1);
        chk32("post_rsp_rdata", if0.rsp_rdata, 32'h0000_0020);
        if0.rsp_ready = 1'b1;
        step(1);
        if0.rsp_ready = 1'b0;
        $display("txn read after reset rdata=0x%08h", if0.rsp_rdata);

        // Custom timing 3/1/2 read
        rd_val1 = 32'hA5A5_0001;
        if1.cmd_write = 1'b0; if1.cmd_addr = ADDR_W; if1.cmd_valid = 1'b1;
        step(1);
        if1.cmd_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) step(1);
            chk1("t_srd", if1.srd, k == 4);
            chk1("t_rsp_valid", if1.rsp_valid, k == 7);
        end
        chk32("t_rsp_rdata", if1.rsp_rdata, 32'hA5A5_0001);
        if1.rsp_ready = 1'b1;
        step(1);
        if1.rsp_ready = 1'b0;
        $display("txn read 3/1/2 rdata=0x%08h", if1.rsp_rdata);

`ifdef SBUS_POLL_EN
        // Poll until match: responder returns 1,1,2
        seq_base0 = srd_pulses0;
        use_seq0 = 1'b1;
        if0.cmd_poll = 1'b1; if0.cmd_write = 1'b0; if0.cmd_addr = ADDR_S;
        if0.cmd_wdata = S_DONE; if0.cmd_valid = 1'b1;
        step(1);
        if0.cmd_valid = 1'b0; if0.cmd_poll = 1'b0;
        n = 0;
        while (!if0.rsp_valid && n < 200) begin
            step(1);
            n++;
        end
        chk1 ("p_rsp_seen", if0.rsp_valid, 1'b1);
        chk32("p_latency", 32'(n + 1), 32'd13);
        chk32("p_pulses", 32'(srd_pulses0 - seq_base0), 32'd3);
        chk32("p_rsp_rdata", if0.rsp_rdata, 32'd2);
        chk1 ("p_timeout", if0.rsp_timeout, 1'b0);
        if0.rsp_ready = 1'b1;
        step(1);
        if0.rsp_ready = 1'b0;
        use_seq0 = 1'b0;
        $display("txn poll addr=0x0120 rdata=0x%08h timeout=%b", if0.rsp_rdata, if0.rsp_timeout);

        // Poll exhausted: POLL_MAX=4, responder stuck at 1
        rd_val1 = 32'd1;
        base = srd_pulses1;
        if1.cmd_poll = 1'b1; if1.cmd_write = 1'b0; if1.cmd_addr = ADDR_S;
        if1.cmd_wdata = S_DONE; if1.cmd_valid = 1'b1;
        step(1);
        if1.cmd_valid = 1'b0; if1.cmd_poll = 1'b0;
        n = 0;
        while (!if1.rsp_valid && n < 200) begin
            step(1);
            n++;
        end
        chk1 ("px_rsp_seen", if1.rsp_valid, 1'b1);
        chk32("px_latency", 32'(n + 1), 32'd25);
        chk32("px_pulses", 32'(srd_pulses1 - base), 32'd4);
        chk32("px_rsp_rdata", if1.rsp_rdata, 32'd1);
        chk1 ("px_timeout", if1.rsp_timeout, 1'b1);
        if1.rsp_ready = 1'b1;
        step(1);
        if1.rsp_ready = 1'b0;
        $display("txn poll exhausted rdata=0x%08h timeout=%b", if1.rsp_rdata, if1.rsp_timeout);
`endif

        chk32("never_both_strobes", 32'(both_high), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sbus_initiator.md
Name: sbus_initiator

Overview:
- Host-side initiator for the simple strobe bus (saddress/srd/swr/sdata_in/sdata_out) that peripheral responders such as the GPIO/prime-count emulator sit on.
- Accepts one read or write command at a time on a valid/ready interface.
- Drives registered address, data and strobes with programmable setup/strobe/hold timing.
- Returns exactly one response per command, carrying read data for reads.

Parameters:
- SETUP_CYC, 1, cycles address/data are stable before the strobe rises (min 1).
- STROBE_CYC, 2, cycles srd/swr are held high (min 1).
- HOLD_CYC, 1, cycles address/data are held after the strobe falls (min 1).
- POLL_MAX, 1024, max read attempts of a poll command (SBUS_POLL_EN only).

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_reset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid && ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_poll  in  1  poll command (ignored/treated as read without SBUS_POLL_EN)
- cmd_addr  in  16  bus address
- cmd_wdata  in  32  write data; expected value for poll
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid && ready
- rsp_rdata  out  32  captured read data (0 for writes)
- rsp_timeout  out  1  poll exhausted POLL_MAX (0 otherwise)
- saddress  out  16  bus address to responder
- sdata_in  out  32  bus write data to responder
- srd  out  1  read strobe
- swr  out  1  write strobe
- sdata_out  in  32  read data from responder

Behaviour:
- Reset (async, n_reset low): state IDLE. All outputs 0 (cmd_ready=0 while in reset, 1 on the first cycle after release). Counters cleared.
- Reset mid-transaction drops srd/swr immediately. No response is produced for the aborted command.
- States: IDLE -> SETUP -> STROBE -> HOLD -> RESP -> IDLE.
- IDLE: cmd_ready=1. On accept, latch cmd_* and drive saddress/sdata_in (sdata_in=0 for reads) from the next cycle. Go to SETUP.
- SETUP: SETUP_CYC cycles, strobes low.
- STROBE: swr (write) or srd (read) high for exactly STROBE_CYC cycles. Never both high. Address/data unchanged.
- HOLD: HOLD_CYC cycles, strobes low, address/data unchanged. On the edge leaving the final HOLD cycle, sample sdata_out into rsp_rdata for reads; rsp_rdata=0 for writes.
- RESP: rsp_valid=1 and stable (rdata/timeout unchanged) until rsp_ready. Leave on handshake. rsp_ready high in the same cycle rsp_valid rises completes in that cycle.
- Latency: accept edge to rsp_valid high = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles. Defaults give 5.
- saddress/sdata_in keep their last values in IDLE/RESP until the next accepted command.
- cmd_ready=0 in every state except IDLE. No pipelining: at most one outstanding command.
- Phase counters are down-counters of width $clog2(max param)+1. Parameter value 1 means a single cycle.

Optional Feature:
- Macro SBUS_POLL_EN.
- Defined, cmd_poll=1 (cmd_write must be 0): repeat full read sequences (SETUP/STROBE/HOLD) at cmd_addr until the sampled sdata_out == cmd_wdata, or POLL_MAX reads are done.
  - Match: response with rsp_rdata = the matching value, rsp_timeout=0.
  - Exhausted: rsp_rdata = last sampled value, rsp_timeout=1.
  - Consecutive reads are separated only by the next SETUP phase.
- Not defined: cmd_poll ignored (plain read), rsp_timeout tied 0, no poll counter logic.

Decomposition:
- Package sbus_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, RESP);
  - responder address constants ADDR_A=16'h0100, ADDR_W=16'h0110, ADDR_S=16'h0120;
  - status constant S_DONE=32'd2.
- One sub-module, sbus_phase_timer: loadable down-counter with a done flag, instantiated once and reloaded per phase.

Test Plan:
- Write 0x100 data 5, defaults -> saddress=0x0100 and sdata_in=5 one cycle after accept; swr high cycles 2-3 after accept; srd never high; rsp_valid at cycle 5 with rsp_rdata=0.
- Read 0x110 against a responder model returning 0x0000000B -> srd high 2 cycles; rsp_rdata=0x0000000B; cmd_ready low from accept until the response handshake.
- Hold rsp_ready low 4 cycles after rsp_valid -> rsp_valid/rsp_rdata stable; second cmd_valid held high is not accepted until the cycle after the handshake.
- Assert n_reset low during STROBE of a write -> swr falls asynchronously; all outputs 0; no rsp_valid after release; the next command completes normally.
- SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2, read -> strobe 1 cycle; rsp_valid 7 cycles after accept.
- SBUS_POLL_EN: poll 0x120 expect 2, model returns 1,1,2 -> three srd pulses, rsp_rdata=2, timeout=0. With POLL_MAX=4 and the model stuck at 1 -> four srd pulses, rsp_timeout=1, rsp_rdata=1.
